rv_int_pipe: RTL and testbench
==============================

# rv_int_pipe

Parametrised three-stage (IF/ID/EX) RV32I integer pipeline executing the OP-IMM, OP and LUI classes with a real register file, writeback and same-cycle bypass. It replaces the addi-only fetch/decode/execute datapath as the core's integer engine. It fetches from instruction memory over a valid-qualified port and reports every retired instruction on a registered trace port. Loads, stores and branches are out of scope and retire as illegal.

## Interface
- RESET_PC, 32'h0000_0000: PC value after reset.
- NREGS, 32: architectural registers, 32 (RV32I) or 16 (RV32E); `rd`/`rs` ≥ NREGS is illegal.
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- imem_addr  out  32  current PC; byte address, always word-aligned.
- imem_insn  in  32  instruction at imem_addr, same cycle (combinational memory).
- imem_valid  in  1  imem_insn usable this cycle; 0 = fetch stall.
- retire_valid  out  1  one instruction retired (registered).
- retire_pc  out  32  PC of retired instruction.
- retire_rd  out  5  destination register (0 if no write).
- retire_wdata  out  32  value written (0 if no write).
- retire_illegal  out  1  retired instruction was unsupported/illegal; no state changed.

## Operation
- IF: when imem_valid=1, latch {pc, imem_insn, valid=1} into IF/ID and pc += 4 (wraps mod 2^32). When imem_valid=0, pc holds and IF/ID valid=0 (bubble).
- ID: decode opcode/funct3/funct7; read rs1/rs2; form I-immediate (sign-extended [31:20]) or U-immediate ([31:12]<<12). Register into ID/EX: valid, pc, rd, operand A, operand B, alu op, write-enable, illegal.
- Bypass: if EX holds a valid writing instruction with rd≠0 and rd equals an ID source register, ID takes the EX result instead of the register file value.
- EX: ALU computes the result. If valid and we and rd≠0, the register file is written at the clock edge. Trace registers are loaded from EX at the same edge.
- Supported operations:
  - OP-IMM: addi, slti, sltiu, xori, ori, andi, slli, srli, srai.
  - OP: add, sub, sll, slt, sltu, xor, or, and, srl, sra.
  - lui.
- Shifts use amount [4:0]. For slli/srli/srai, funct7 must be 0000000 (srai: 0100000), otherwise illegal. slt/slti are signed compares; sltu/sltiu are unsigned.
- Illegal instructions: any other opcode, bad funct7, or register index ≥ NREGS. They retire with retire_illegal=1, retire_rd=0, retire_wdata=0 and cause no write.
- x0 reads 0 and writes to it are dropped. An instruction with rd=0 retires with retire_rd=0, retire_wdata=0.

## Timing
- Reset (rst_n=0 at a clk edge):
  - pc=RESET_PC, all stage valids 0, register file cleared to 0.
  - retire_* all 0; imem_addr=RESET_PC in the first cycle after release.
- Latency: an instruction fetched in cycle N is decoded in N+1, executes and writes in N+2, and retire_valid=1 in N+3.
- Throughput: 1 instruction per cycle when imem_valid=1. There are no data-hazard stalls (full bypass).
- Each cycle of imem_valid=0 produces exactly one non-retiring bubble, 3 cycles later.
- Reset mid-operation: all in-flight instructions are discarded without writing. No retire occurs for them.
- PC wrap: 32'hFFFF_FFFC + 4 gives 0 with no error.
- Simultaneous ID read and EX write of the same register: the bypass value wins (never a stale read).

## Structure
- Package `rv_pkg`:
  - opcode constants (OP_IMM=7'b0010011, OP=7'b0110011, LUI=7'b0110111);
  - funct3 constants;
  - `alu_op_e` enum (ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, PASSB);
  - `id_ex_t` packed struct.
- Sub-module `rv_alu`: combinational; inputs a, b, `alu_op_e`; output result.
- Register file is inline: NREGS×32 flops, 2 read ports, 1 write port.

## Test plan
- Reset with RESET_PC=32'h100 -> imem_addr=0x100 and retire_valid=0 for 3 cycles; imem_addr then advances 0x104, 0x108, …
- addi x1,x0,5 (0x00500093) at 0x100 -> in cycle N+3: retire_pc=0x100, rd=1, wdata=5, illegal=0.
- Back-to-back addi x1,x0,5 then addi x2,x1,3 -> x2 retires with wdata=8 (bypass), no stall cycle.
- lui x1,0xFFFFF; addi x1,x1,-16 (x1=0xFFFFEFF0); srai x3,x1,2 -> 0xFFFFFBFC; srli x4,x1,28 -> 0xF; sltu x5,x0,x1 -> 1; slt x6,x1,x0 -> 1.
- imem_valid=0 for 2 cycles mid-stream -> pc held, exactly 2 bubble cycles on retire_valid, program results unchanged.
- Illegal and dropped writes:
  - 0x00000073 (ecall) -> retire_illegal=1, rd=0, no write.
  - addi x0,x0,7 -> retire_rd=0, x0 still reads 0.
  - With NREGS=16, addi x20,x0,1 -> illegal.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared encodings for the rv_int_pipe integer pipeline: opcodes, funct
// fields, ALU operation enum and the ID/EX pipeline register layout.
package rv_pkg;

   localparam logic [6:0] OP_IMM = 7'b0010011;
   localparam logic [6:0] OP     = 7'b0110011;
   localparam logic [6:0] LUI    = 7'b0110111;

   localparam logic [2:0] F3_ADD  = 3'b000;
   localparam logic [2:0] F3_SLL  = 3'b001;
   localparam logic [2:0] F3_SLT  = 3'b010;
   localparam logic [2:0] F3_SLTU = 3'b011;
   localparam logic [2:0] F3_XOR  = 3'b100;
   localparam logic [2:0] F3_SR   = 3'b101;
   localparam logic [2:0] F3_OR   = 3'b110;
   localparam logic [2:0] F3_AND  = 3'b111;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   typedef enum logic [3:0] {
      ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, PASSB
   } alu_op_e;

   typedef struct packed {
      logic        valid;
      logic [31:0] pc;
      logic [4:0]  rd;
      logic [31:0] op_a;
      logic [31:0] op_b;
      alu_op_e     op;
      logic        we;
      logic        illegal;
   } id_ex_t;

   // funct3 selects the operation for OP-IMM and for OP with funct7=0;
   // the funct7=0100000 variants (sub, sra/srai) are patched by the decoder.
   function automatic alu_op_e f3_base_op(input logic [2:0] f3);
      alu_op_e op;
      case (f3)
         F3_ADD:  op = ADD;
         F3_SLL:  op = SLL;
         F3_SLT:  op = SLT;
         F3_SLTU: op = SLTU;
         F3_XOR:  op = XOR;
         F3_SR:   op = SRL;
         F3_OR:   op = OR;
         default: op = AND;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/rv_alu.sv
// Combinational integer ALU; shift amounts use b[4:0].
module rv_alu
   import rv_pkg::*;
(
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  alu_op_e     op,
   output logic [31:0] result
);

   // Select the result for the requested operation.
   always_comb begin
      result = '0;
      case (op)
         ADD:     result = a + b;
         SUB:     result = a - b;
         SLL:     result = a << b[4:0];
         SLT:     result = {31'd0, $signed(a) < $signed(b)};
         SLTU:    result = {31'd0, a < b};
         XOR:     result = a ^ b;
         SRL:     result = a >> b[4:0];
         SRA:     result = $signed(a) >>> b[4:0];
         OR:      result = a | b;
         AND:     result = a & b;
         PASSB:   result = b;
         default: result = '0;
      endcase
   end

endmodule

// File: rtl/rv_int_pipe.sv
// Three-stage (IF/ID/EX) RV32I integer pipeline for OP-IMM, OP and LUI with
// an inline register file, EX->ID bypass and a registered retire trace.
module rv_int_pipe
   import rv_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          NREGS    = 32
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_insn,
   input  logic        imem_valid,
   output logic        retire_valid,
   output logic [31:0] retire_pc,
   output logic [4:0]  retire_rd,
   output logic [31:0] retire_wdata,
   output logic        retire_illegal
);

   localparam int         AW      = $clog2(NREGS);
   localparam logic [5:0] NREGS_L = 6'(NREGS);

   logic [31:0] pc_q, pc_d;
   logic        ifid_valid_q, ifid_valid_d;
   logic [31:0] ifid_pc_q, ifid_pc_d;
   logic [31:0] ifid_insn_q, ifid_insn_d;
   id_ex_t      idex_q, idex_d;
   logic        rt_valid_q, rt_valid_d;
   logic [31:0] rt_pc_q, rt_pc_d;
   logic [4:0]  rt_rd_q, rt_rd_d;
   logic [31:0] rt_wdata_q, rt_wdata_d;
   logic        rt_illegal_q, rt_illegal_d;

   logic [31:0] regs_q [NREGS];
   logic [31:0] regs_d [NREGS];

   logic [31:0] ex_result;
   logic        ex_wr;

   // ---------------- IF ----------------
   assign imem_addr = pc_q;

   // Fetch on imem_valid, otherwise hold the PC and inject a bubble.
   always_comb begin
      pc_d         = pc_q;
      ifid_valid_d = imem_valid;
      ifid_pc_d    = ifid_pc_q;
      ifid_insn_d  = ifid_insn_q;
      if (imem_valid) begin
         pc_d        = pc_q + 32'd4;
         ifid_pc_d   = pc_q;
         ifid_insn_d = imem_insn;
      end
   end

   // ---------------- ID ----------------
   logic [6:0]       id_opc;
   logic [4:0]       id_rd;
   logic [2:0]       id_f3;
   logic [6:0]       id_f7;
   logic [31:0]      imm_i, imm_u;
   logic [1:0][4:0]  rs_idx;
   logic [1:0][31:0] rs_val;

   assign id_opc = ifid_insn_q[6:0];
   assign id_rd  = ifid_insn_q[11:7];
   assign id_f3  = ifid_insn_q[14:12];
   assign id_f7  = ifid_insn_q[31:25];
   assign imm_i  = {{20{ifid_insn_q[31]}}, ifid_insn_q[31:20]};
   assign imm_u  = {ifid_insn_q[31:12], 12'd0};
   assign rs_idx = {ifid_insn_q[24:20], ifid_insn_q[19:15]};

   // Read ports: x0 is hard zero, and an EX result for the same register
   // overrides the file so a same-cycle write is never read stale.
   for (genvar gi = 0; gi < 2; gi++) begin : g_rd_port
      logic [AW-1:0] ra;
      assign ra = rs_idx[gi][AW-1:0];
      assign rs_val[gi] = (rs_idx[gi] == 5'd0)                 ? 32'd0     :
                          (ex_wr && idex_q.rd == rs_idx[gi])   ? ex_result :
                                                                 regs_q[ra];
   end

   logic        dec_ill, use_rs1, use_rs2;
   alu_op_e     dec_op;
   logic [31:0] dec_a, dec_b;

   // Decode operation, operands and legality of the instruction in ID.
   always_comb begin
      dec_op  = f3_base_op(id_f3);
      dec_ill = 1'b0;
      dec_a   = rs_val[0];
      dec_b   = rs_val[1];
      use_rs1 = 1'b0;
      use_rs2 = 1'b0;
      case (id_opc)
         OP_IMM: begin
            use_rs1 = 1'b1;
            dec_b   = imm_i;
            if (id_f3 == F3_SLL && id_f7 != F7_BASE) dec_ill = 1'b1;
            if (id_f3 == F3_SR) begin
               if (id_f7 == F7_ALT)       dec_op  = SRA;
               else if (id_f7 != F7_BASE) dec_ill = 1'b1;
            end
         end
         OP: begin
            use_rs1 = 1'b1;
            use_rs2 = 1'b1;
            if (id_f7 == F7_ALT && id_f3 == F3_ADD)     dec_op  = SUB;
            else if (id_f7 == F7_ALT && id_f3 == F3_SR) dec_op  = SRA;
            else if (id_f7 != F7_BASE)                  dec_ill = 1'b1;
         end
         LUI: begin
            dec_a  = '0;
            dec_b  = imm_u;
            dec_op = PASSB;
         end
         default: dec_ill = 1'b1;
      endcase
      if (({1'b0, id_rd} >= NREGS_L) ||
          (use_rs1 && {1'b0, rs_idx[0]} >= NREGS_L) ||
          (use_rs2 && {1'b0, rs_idx[1]} >= NREGS_L))
         dec_ill = 1'b1;
   end

   // Build the ID/EX register contents; a bubble leaves everything zero.
   always_comb begin
      idex_d = '0;
      if (ifid_valid_q) begin
         idex_d.valid   = 1'b1;
         idex_d.pc      = ifid_pc_q;
         idex_d.rd      = id_rd;
         idex_d.op_a    = dec_a;
         idex_d.op_b    = dec_b;
         idex_d.op      = dec_op;
         idex_d.illegal = dec_ill;
         idex_d.we      = !dec_ill && (id_rd != 5'd0);
      end
   end

   // ---------------- EX ----------------
   rv_alu u_alu (
      .a      (idex_q.op_a),
      .b      (idex_q.op_b),
      .op     (idex_q.op),
      .result (ex_result)
   );

   assign ex_wr = idex_q.valid && idex_q.we && (idex_q.rd != 5'd0);

   // Register file: one flop word per register, written from EX.
   for (genvar gi = 0; gi < NREGS; gi++) begin : g_reg
      assign regs_d[gi] = (ex_wr && idex_q.rd == 5'(gi)) ? ex_result : regs_q[gi];
      // Clear on reset, otherwise take the EX write for this index.
      always_ff @(posedge clk) begin
         if (!rst_n) regs_q[gi] <= '0;
         else        regs_q[gi] <= regs_d[gi];
      end
   end

   // Trace record for the instruction leaving EX; non-writers report rd/wdata 0.
   always_comb begin
      rt_valid_d   = idex_q.valid;
      rt_pc_d      = idex_q.valid ? idex_q.pc : 32'd0;
      rt_rd_d      = ex_wr ? idex_q.rd : 5'd0;
      rt_wdata_d   = ex_wr ? ex_result : 32'd0;
      rt_illegal_d = idex_q.valid && idex_q.illegal;
   end

   // Pipeline and trace registers; reset discards everything in flight.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pc_q         <= RESET_PC;
         ifid_valid_q <= 1'b0;
         ifid_pc_q    <= '0;
         ifid_insn_q  <= '0;
         idex_q       <= '0;
         rt_valid_q   <= 1'b0;
         rt_pc_q      <= '0;
         rt_rd_q      <= '0;
         rt_wdata_q   <= '0;
         rt_illegal_q <= 1'b0;
      end else begin
         pc_q         <= pc_d;
         ifid_valid_q <= ifid_valid_d;
         ifid_pc_q    <= ifid_pc_d;
         ifid_insn_q  <= ifid_insn_d;
         idex_q       <= idex_d;
         rt_valid_q   <= rt_valid_d;
         rt_pc_q      <= rt_pc_d;
         rt_rd_q      <= rt_rd_d;
         rt_wdata_q   <= rt_wdata_d;
         rt_illegal_q <= rt_illegal_d;
      end
   end

   assign retire_valid   = rt_valid_q;
   assign retire_pc      = rt_pc_q;
   assign retire_rd      = rt_rd_q;
   assign retire_wdata   = rt_wdata_q;
   assign retire_illegal = rt_illegal_q;

endmodule

// File: tb/tb_rv_int_pipe.sv
// Bench for rv_int_pipe: two instances (RV32I at 0x100, RV32E at 0xFFFFFFF0
// so the PC wraps) share one instruction stream and are checked against an
// architectural model delayed by the three-cycle retire latency.
module tb_rv_int_pipe;

   typedef struct packed {
      logic        v;
      logic [31:0] pc;
      logic [4:0]  rd;
      logic [31:0] w;
      logic        ill;
   } rec_t;

   logic             clk;
   logic             rst_n;
   logic [31:0]      imem_insn;
   logic             imem_valid;
   logic [1:0][31:0] addr;
   logic [1:0]       rv;
   logic [1:0][31:0] rpc;
   logic [1:0][4:0]  rrd;
   logic [1:0][31:0] rwd;
   logic [1:0]       ril;

   int total = 0;
   int bad   = 0;

   logic [31:0] mregs [2][32];
   logic [31:0] mpc   [2];
   rec_t        dl    [2][3];
   logic [31:0] cap_w   [2][64];
   logic [4:0]  cap_rd  [2][64];
   logic        cap_ill [2][64];

   logic [31:0] prog [12] = '{
      32'h00500093,  // addi x1,x0,5
      32'h00308113,  // addi x2,x1,3
      32'hFFFFF0B7,  // lui  x1,0xFFFFF
      32'hFF008093,  // addi x1,x1,-16
      32'h4020D193,  // srai x3,x1,2
      32'h01C0D213,  // srli x4,x1,28
      32'h001032B3,  // sltu x5,x0,x1
      32'h0000A333,  // slt  x6,x1,x0
      32'h00000073,  // ecall
      32'h00700013,  // addi x0,x0,7
      32'h002003B3,  // add  x7,x0,x2
      32'h00100A13   // addi x20,x0,1
   };

   rv_int_pipe #(.RESET_PC(32'h0000_0100), .NREGS(32)) u_dut32 (
      .clk(clk), .rst_n(rst_n), .imem_addr(addr[0]), .imem_insn(imem_insn),
      .imem_valid(imem_valid), .retire_valid(rv[0]), .retire_pc(rpc[0]),
      .retire_rd(rrd[0]), .retire_wdata(rwd[0]), .retire_illegal(ril[0])
   );

   rv_int_pipe #(.RESET_PC(32'hFFFF_FFF0), .NREGS(16)) u_dut16 (
      .clk(clk), .rst_n(rst_n), .imem_addr(addr[1]), .imem_insn(imem_insn),
      .imem_valid(imem_valid), .retire_valid(rv[1]), .retire_pc(rpc[1]),
      .retire_rd(rrd[1]), .retire_wdata(rwd[1]), .retire_illegal(ril[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h expected=%h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] base_pc(input int k);
      return (k == 0) ? 32'h0000_0100 : 32'hFFFF_FFF0;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         for (int r = 0; r < 32; r++) mregs[k][r] = '0;
         for (int s = 0; s < 3; s++) dl[k][s] = '0;
         mpc[k] = base_pc(k);
      end
   endtask

   // Architectural effect of one instruction on instance k's register view.
   task automatic model_exec(input int k, input logic [31:0] insn, output rec_t r);
      int          n;
      logic [6:0]  opc, f7;
      logic [4:0]  rd, rs1, rs2;
      logic [2:0]  f3;
      logic [31:0] a, b, imm, res;
      logic        ill;
      n   = (k == 0) ? 32 : 16;
      opc = insn[6:0];  rd = insn[11:7];  f3 = insn[14:12];
      rs1 = insn[19:15]; rs2 = insn[24:20]; f7 = insn[31:25];
      imm = {{20{insn[31]}}, insn[31:20]};
      a   = mregs[k][rs1];
      b   = mregs[k][rs2];
      ill = 1'b0;
      res = '0;
      if (opc == 7'h13) begin
         if (int'(rd) >= n || int'(rs1) >= n) ill = 1'b1;
         case (f3)
            3'd0: res = a + imm;
            3'd2: res = ($signed(a) < $signed(imm)) ? 32'd1 : 32'd0;
            3'd3: res = (a < imm) ? 32'd1 : 32'd0;
            3'd4: res = a ^ imm;
            3'd6: res = a | imm;
            3'd7: res = a & imm;
            3'd1: if (f7 != 7'h00) ill = 1'b1; else res = a << rs2;
            default: begin
               if (f7 == 7'h00)      res = a >> rs2;
               else if (f7 == 7'h20) res = $signed(a) >>> rs2;
               else                  ill = 1'b1;
            end
         endcase
      end else if (opc == 7'h33) begin
         if (int'(rd) >= n || int'(rs1) >= n || int'(rs2) >= n) ill = 1'b1;
         if (f7 == 7'h20 && f3 == 3'd0)      res = a - b;
         else if (f7 == 7'h20 && f3 == 3'd5) res = $signed(a) >>> b[4:0];
         else if (f7 != 7'h00)               ill = 1'b1;
         else begin
            case (f3)
               3'd0: res = a + b;
               3'd1: res = a << b[4:0];
               3'd2: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
               3'd3: res = (a < b) ? 32'd1 : 32'd0;
               3'd4: res = a ^ b;
               3'd5: res = a >> b[4:0];
               3'd6: res = a | b;
               default: res = a & b;
            endcase
         end
      end else if (opc == 7'h37) begin
         if (int'(rd) >= n) ill = 1'b1;
         res = {insn[31:12], 12'd0};
      end else begin
         ill = 1'b1;
      end
      r.v   = 1'b1;
      r.pc  = mpc[k];
      r.ill = ill;
      if (!ill && rd != 5'd0) begin
         mregs[k][rd] = res;
         r.rd = rd;
         r.w  = res;
      end else begin
         r.rd = 5'd0;
         r.w  = 32'd0;
      end
   endtask

   task automatic check_outputs();
      int idx;
      for (int k = 0; k < 2; k++) begin
         chk($sformatf("d%0d.imem_addr", k), addr[k], mpc[k]);
         chk($sformatf("d%0d.retire_valid", k), {31'd0, rv[k]}, {31'd0, dl[k][2].v});
         if (dl[k][2].v) begin
            chk($sformatf("d%0d.retire_pc", k), rpc[k], dl[k][2].pc);
            chk($sformatf("d%0d.retire_rd", k), {27'd0, rrd[k]}, {27'd0, dl[k][2].rd});
            chk($sformatf("d%0d.retire_wdata", k), rwd[k], dl[k][2].w);
            chk($sformatf("d%0d.retire_illegal", k), {31'd0, ril[k]}, {31'd0, dl[k][2].ill});
         end
         if (rv[k]) begin
            $display("retire d%0d pc=%h rd=%0d wdata=%h illegal=%0d",
                     k, rpc[k], rrd[k], rwd[k], ril[k]);
            idx = int'((rpc[k] - base_pc(k)) >> 2) & 63;
            cap_w[k][idx]   = rwd[k];
            cap_rd[k][idx]  = rrd[k];
            cap_ill[k][idx] = ril[k];
         end
      end
   endtask

   task automatic check_reset_outputs();
      for (int k = 0; k < 2; k++) begin
         chk($sformatf("d%0d.rst.imem_addr", k), addr[k], base_pc(k));
         chk($sformatf("d%0d.rst.retire_valid", k), {31'd0, rv[k]}, 32'd0);
         chk($sformatf("d%0d.rst.retire_pc", k), rpc[k], 32'd0);
         chk($sformatf("d%0d.rst.retire_rd", k), {27'd0, rrd[k]}, 32'd0);
         chk($sformatf("d%0d.rst.retire_wdata", k), rwd[k], 32'd0);
         chk($sformatf("d%0d.rst.retire_illegal", k), {31'd0, ril[k]}, 32'd0);
      end
   endtask

   // One clock: check this cycle's outputs, drive inputs, advance the model.
   task automatic cycle(input logic iv, input logic [31:0] insn);
      rec_t r;
      check_outputs();
      imem_valid = iv;
      imem_insn  = insn;
      for (int k = 0; k < 2; k++) begin
         r = '0;
         if (iv) begin
            model_exec(k, insn, r);
            mpc[k] = mpc[k] + 32'd4;
         end
         dl[k][2] = dl[k][1];
         dl[k][1] = dl[k][0];
         dl[k][0] = r;
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   function automatic logic [4:0] pick_reg();
      if ($urandom_range(0, 5) == 0) return 5'($urandom_range(0, 31));
      return 5'($urandom_range(0, 7));
   endfunction

   function automatic logic [31:0] rand_insn();
      int         sel;
      logic [6:0] f7;
      sel = $urandom_range(0, 9);
      case ($urandom_range(0, 3))
         0:       f7 = 7'h00;
         1:       f7 = 7'h20;
         2:       f7 = 7'h00;
         default: f7 = 7'($urandom_range(0, 127));
      endcase
      if (sel <= 3)
         return {f7, pick_reg(), pick_reg(), 3'($urandom_range(0, 7)), pick_reg(), 7'h13};
      if (sel <= 6)
         return {f7, pick_reg(), pick_reg(), 3'($urandom_range(0, 7)), pick_reg(), 7'h33};
      if (sel == 7)
         return {20'($urandom), pick_reg(), 7'h37};
      if (sel == 8)
         return $urandom;
      return {12'($urandom), pick_reg(), 3'($urandom_range(0, 7)), pick_reg(), 7'h13};
   endfunction

   initial begin
      for (int k = 0; k < 2; k++)
         for (int i = 0; i < 64; i++) begin
            cap_w[k][i]   = 32'hDEAD_BEEF;
            cap_rd[k][i]  = 5'h1F;
            cap_ill[k][i] = 1'bx;
         end
      rst_n      = 1'b0;
      imem_valid = 1'b0;
      imem_insn  = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset_outputs();
      rst_n = 1'b1;
      model_reset();

      // Directed program with a two-cycle fetch stall in the middle.
      for (int i = 0; i < 12; i++) begin
         if (i == 8) begin
            cycle(1'b0, 32'h0);
            cycle(1'b0, 32'h0);
         end
         cycle(1'b1, prog[i]);
      end
      repeat (4) cycle(1'b0, 32'h0);

      chk("addi x1 wdata", cap_w[0][0], 32'd5);
      chk("addi x1 rd", {27'd0, cap_rd[0][0]}, 32'd1);
      chk("bypass x2 wdata", cap_w[0][1], 32'd8);
      chk("lui x1 wdata", cap_w[0][2], 32'hFFFF_F000);
      chk("addi -16 wdata", cap_w[0][3], 32'hFFFF_EFF0);
      chk("srai x3 wdata", cap_w[0][4], 32'hFFFF_FBFC);
      chk("srli x4 wdata", cap_w[0][5], 32'h0000_000F);
      chk("sltu x5 wdata", cap_w[0][6], 32'd1);
      chk("slt x6 wdata", cap_w[0][7], 32'd1);
      chk("ecall illegal", {31'd0, cap_ill[0][8]}, 32'd1);
      chk("ecall rd", {27'd0, cap_rd[0][8]}, 32'd0);
      chk("addi x0 rd", {27'd0, cap_rd[0][9]}, 32'd0);
      chk("addi x0 wdata", cap_w[0][9], 32'd0);
      chk("x0 reads zero", cap_w[0][10], 32'd8);
      chk("x20 legal rv32i", cap_w[0][11], 32'd1);
      chk("x20 illegal rv32e", {31'd0, cap_ill[1][11]}, 32'd1);
      chk("x20 rv32e rd", {27'd0, cap_rd[1][11]}, 32'd0);
      chk("wrap srai rv32e", cap_w[1][4], 32'hFFFF_FBFC);

      // Random stream with occasional fetch stalls.
      for (int i = 0; i < 300; i++)
         cycle($urandom_range(0, 7) != 0, rand_insn());

      // Reset while instructions are in flight, fetch still offered.
      rst_n      = 1'b0;
      imem_valid = 1'b1;
      imem_insn  = 32'h00500093;
      repeat (2) begin
         @(posedge clk);
         @(negedge clk);
         check_reset_outputs();
      end
      rst_n = 1'b1;
      model_reset();

      for (int i = 0; i < 200; i++)
         cycle($urandom_range(0, 5) != 0, rand_insn());
      repeat (4) cycle(1'b0, 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
